// File: rtl/ro_window_counter.sv
// ro_window_counter
//   Multi-channel ring-oscillator edge counter. Each RO input is synchronised
//   into the Clock domain and edge-detected. The detected edges are prescaled
//   by 2^DIV_LOG2 and counted, with saturation, over a window of Window Clock
//   cycles. At the end of the window the block produces the RO PUF response
//   bit, which is 1 when channel 0 counted more than channel 1.
//
// Ports
//   Clock   : system clock, rising edge
//   Reset   : asynchronous, active-low reset
//   Ro_in   : NUM_CH ring-oscillator outputs, asynchronous to Clock
//   Start   : begin a measurement (accepted only when idle)
//   Window  : window length in Clock cycles, sampled together with Start
//   Busy    : high while the window is open
//   Done    : one-cycle pulse when Counts/Sat/Resp are valid
//   Counts  : per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   Sat     : per-channel sticky saturation flags
//   Resp    : response bit, count0 > count1 (unsigned)
module ro_window_counter #(
    parameter int CNT_W       = 32,
    parameter int NUM_CH      = 2,
    parameter int WIN_W       = 16,
    parameter int DIV_LOG2    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       Ro_in,
    input  logic                    Start,
    input  logic [WIN_W-1:0]        Window,
    output logic                    Busy,
    output logic                    Done,
    output logic [NUM_CH*CNT_W-1:0] Counts,
    output logic [NUM_CH-1:0]       Sat,
    output logic                    Resp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [WIN_W-1:0]          win_cnt_reg, win_cnt_next;
    logic                      resp_reg, resp_next;
    logic                      start_accept;
    logic                      resp_cmp;
    logic [NUM_CH*CNT_W-1:0]   cnt_next_flat;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        win_cnt_next = win_cnt_reg;
        start_accept = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    start_accept = 1'b1;
                    win_cnt_next = Window;
                    // A zero-length window skips straight to the result cycle.
                    state_next   = (Window == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                win_cnt_next = win_cnt_reg - 1'b1;
                if (win_cnt_reg == WIN_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Resp is captured on the transition into DONE from the final counts
    // (including any increment from the last window cycle), so it is already
    // valid while Done is high.
    always_comb begin
        resp_next = resp_reg;
        if (start_accept) begin
            resp_next = 1'b0;
        end else if (state_reg == ST_RUN && state_next == ST_DONE) begin
            resp_next = resp_cmp;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= ST_IDLE;
            win_cnt_reg <= '0;
            resp_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            win_cnt_reg <= win_cnt_next;
            resp_reg    <= resp_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel front end, prescaler and saturating counter
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   detect_reg;
            logic                   wrap;
            logic                   inc;
            logic [CNT_W-1:0]       cnt_reg, cnt_next;
            logic                   sat_reg, sat_next;

            // Synchroniser and registered rising-edge detect; the detect
            // pulse appears SYNC_STAGES+1 cycles after the input rises.
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    sync_reg   <= '0;
                    prev_reg   <= 1'b0;
                    detect_reg <= 1'b0;
                end else begin
                    sync_reg   <= {sync_reg[SYNC_STAGES-2:0], Ro_in[gi]};
                    prev_reg   <= sync_reg[SYNC_STAGES-1];
                    detect_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
                end
            end

            if (DIV_LOG2 == 0) begin : g_nodiv
                assign wrap = detect_reg;
            end else begin : g_div
                logic [DIV_LOG2-1:0] pre_reg;

                // Remainder is dropped at the next accepted Start.
                always_ff @(posedge Clock or negedge Reset) begin
                    if (!Reset) begin
                        pre_reg <= '0;
                    end else if (start_accept) begin
                        pre_reg <= '0;
                    end else if (state_reg == ST_RUN && detect_reg) begin
                        pre_reg <= pre_reg + 1'b1;
                    end
                end

                assign wrap = detect_reg & (&pre_reg);
            end

            assign inc = (state_reg == ST_RUN) && wrap;

            always_comb begin
                cnt_next = cnt_reg;
                sat_next = sat_reg;
                if (start_accept) begin
                    cnt_next = '0;
                    sat_next = 1'b0;
                end else if (inc) begin
                    if (&cnt_reg) begin
                        sat_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    cnt_reg <= '0;
                    sat_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    sat_reg <= sat_next;
                end
            end

            assign cnt_next_flat[gi*CNT_W +: CNT_W] = cnt_next;
            assign Counts[gi*CNT_W +: CNT_W]        = cnt_reg;
            assign Sat[gi]                          = sat_reg;
        end

        if (NUM_CH >= 2) begin : g_resp
            assign resp_cmp = cnt_next_flat[0 +: CNT_W] > cnt_next_flat[CNT_W +: CNT_W];
        end else begin : g_noresp
            assign resp_cmp = 1'b0;
        end
    endgenerate

    assign Busy = (state_reg == ST_RUN);
    assign Done = (state_reg == ST_DONE);
    assign Resp = resp_reg;

endmodule

// File: tb/tb_ro_window_counter.sv
module tb_ro_window_counter;

    localparam int SYNC = 2;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [1:0]  ro_in;
    logic [15:0] Window;

    logic        busy, done, resp;
    logic [63:0] counts;
    logic [1:0]  sat;
    logic        busy_s, done_s, resp_s;
    logic [7:0]  counts_s;
    logic [1:0]  sat_s;

    // Default configuration: 32-bit counts, /8 prescale.
    ro_window_counter dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Ro_in  (ro_in),
        .Start  (Start),
        .Window (Window),
        .Busy   (busy),
        .Done   (done),
        .Counts (counts),
        .Sat    (sat),
        .Resp   (resp)
    );

    // Small configuration: 4-bit counts, no prescale, exercises saturation.
    ro_window_counter #(.CNT_W(4), .DIV_LOG2(0)) dut_s (
        .Clock  (Clock),
        .Reset  (Reset),
        .Ro_in  (ro_in),
        .Start  (Start),
        .Window (Window),
        .Busy   (busy_s),
        .Done   (done_s),
        .Counts (counts_s),
        .Sat    (sat_s),
        .Resp   (resp_s)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run_id   = 0;
    int per [2];
    int ph  [2];
    bit en  [2];
    int det0 [$];
    int det1 [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the RO square waves for the new cycle, log every
    // rise with the cycle its detect pulse is due, and return mid-cycle.
    task automatic step();
        @(posedge Clock);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            logic lvl;
            lvl = en[i] && (((cyc + ph[i]) % per[i]) < (per[i] / 2));
            if (lvl && !ro_in[i]) begin
                if (i == 0) det0.push_back(cyc + SYNC + 1);
                else        det1.push_back(cyc + SYNC + 1);
            end
            ro_in[i] = lvl;
        end
        @(negedge Clock);
    endtask

    function automatic int n_detect(input int ch, input int lo, input int hi);
        int n;
        n = 0;
        if (ch == 0) begin
            foreach (det0[k]) if (det0[k] >= lo && det0[k] <= hi) n++;
        end else begin
            foreach (det1[k]) if (det1[k] >= lo && det1[k] <= hi) n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] exp_cnt(input int n, input int dl, input int cw);
        logic [63:0] q, mx;
        q  = 64'(n) >> dl;
        mx = (64'd1 << cw) - 64'd1;
        return (q > mx) ? mx : q;
    endfunction

    function automatic logic exp_sat(input int n, input int dl, input int cw);
        logic [63:0] q, mx;
        q  = 64'(n) >> dl;
        mx = (64'd1 << cw) - 64'd1;
        return q > mx;
    endfunction

    // One measurement; optionally pokes Start/Window mid-run to show they are ignored.
    task automatic run_measure(input int w, input bit poke);
        int          t, busy_cnt, n0, n1;
        logic [63:0] e0, e1, es0, es1, held;
        logic        xs0, xs1, xss0, xss1;
        Window   = 16'(w);
        Start    = 1'b1;
        t        = cyc;
        step();
        Start    = 1'b0;
        busy_cnt = 0;
        while (!done && cyc < t + w + 10) begin
            if (busy) busy_cnt++;
            if (poke && (cyc == t + 50 || cyc == t + 200)) begin
                Start  = 1'b1;
                Window = 16'd5;
            end else begin
                Start  = 1'b0;
            end
            step();
        end
        Start = 1'b0;

        n0   = n_detect(0, t + 1, t + w);
        n1   = n_detect(1, t + 1, t + w);
        e0   = exp_cnt(n0, 3, 32);
        e1   = exp_cnt(n1, 3, 32);
        es0  = exp_cnt(n0, 0, 4);
        es1  = exp_cnt(n1, 0, 4);
        xs0  = exp_sat(n0, 3, 32);
        xs1  = exp_sat(n1, 3, 32);
        xss0 = exp_sat(n0, 0, 4);
        xss1 = exp_sat(n1, 0, 4);

        check_val("done",      64'(done),      64'd1);
        check_val("done_s",    64'(done_s),    64'd1);
        check_val("done_lat",  64'(cyc - t),   64'(w + 1));
        check_val("busy_done", 64'(busy),      64'd0);
        check_val("busy_len",  64'(busy_cnt),  64'(w));
        check_val("cnt0",      64'(counts[31:0]),  e0);
        check_val("cnt1",      64'(counts[63:32]), e1);
        check_val("sat",       64'(sat),       64'({xs1, xs0}));
        check_val("resp",      64'(resp),      64'(e0 > e1));
        check_val("cnt0_s",    64'(counts_s[3:0]), es0);
        check_val("cnt1_s",    64'(counts_s[7:4]), es1);
        check_val("sat_s",     64'(sat_s),     64'({xss1, xss0}));
        check_val("resp_s",    64'(resp_s),    64'(es0 > es1));
        $display("run %0d w=%0d per=%0d/%0d n=%0d/%0d cnt=%0d/%0d cnt_s=%0d/%0d resp=%0d poke=%0d",
                 run_id, w, per[0], per[1], n0, n1, counts[31:0], counts[63:32],
                 counts_s[3:0], counts_s[7:4], resp, poke);
        run_id++;

        held = counts;
        step();
        check_val("done_pulse", 64'(done),   64'd0);
        check_val("cnt_hold",   counts,      held);
    endtask

    task automatic set_waves(input int p0, input int p1, input bit e0, input bit e1);
        per[0] = p0; per[1] = p1;
        ph[0]  = 0;  ph[1]  = 0;
        en[0]  = e0; en[1]  = e1;
    endtask

    initial begin
        Reset  = 1'b0;
        Start  = 1'b0;
        Window = 16'd0;
        ro_in  = 2'b00;
        set_waves(4, 4, 1'b0, 1'b0);
        repeat (3) step();
        Reset = 1'b1;
        step();
        check_val("rst_busy",   64'(busy),     64'd0);
        check_val("rst_done",   64'(done),     64'd0);
        check_val("rst_counts", counts,        64'd0);
        check_val("rst_sat",    64'(sat),      64'd0);
        check_val("rst_resp",   64'(resp),     64'd0);

        // 800-cycle window, ch0 period 4: 200 detects -> 25.
        set_waves(4, 6, 1'b1, 1'b1);
        repeat (10) step();
        run_measure(800, 1'b0);
        check_val("tp800_ch0", 64'(counts[31:0]), 64'd25);

        // 300 vs 200 edges -> 37 vs 25, Resp=1.
        run_measure(1200, 1'b0);
        check_val("tp1200_ch0",  64'(counts[31:0]),  64'd37);
        check_val("tp1200_ch1",  64'(counts[63:32]), 64'd25);
        check_val("tp1200_resp", 64'(resp),          64'd1);

        set_waves(6, 4, 1'b1, 1'b1);
        repeat (10) step();
        run_measure(1200, 1'b0);
        check_val("swap_resp", 64'(resp), 64'd0);

        set_waves(4, 4, 1'b1, 1'b1);
        repeat (10) step();
        run_measure(1200, 1'b0);
        check_val("tie_resp", 64'(resp), 64'd0);

        // Saturation in the 4-bit instance, then cleared by the next run.
        set_waves(2, 4, 1'b1, 1'b0);
        repeat (10) step();
        run_measure(100, 1'b0);
        check_val("sat_cnt",  64'(counts_s[3:0]), 64'd15);
        check_val("sat_flag", 64'(sat_s[0]),      64'd1);
        run_measure(20, 1'b0);
        check_val("unsat_cnt",  64'(counts_s[3:0]), 64'd10);
        check_val("unsat_flag", 64'(sat_s[0]),      64'd0);

        // Zero-length window.
        set_waves(4, 6, 1'b1, 1'b1);
        run_measure(0, 1'b0);

        // Start/Window changes during the run are ignored.
        run_measure(300, 1'b1);

        // Asynchronous reset in the middle of a long run.
        set_waves(4, 4, 1'b1, 1'b1);
        Window = 16'd1000;
        Start  = 1'b1;
        step();
        Start  = 1'b0;
        repeat (100) step();
        check_val("busy_pre_rst", 64'(busy), 64'd1);
        en[0] = 1'b0;
        en[1] = 1'b0;
        ro_in = 2'b00;
        Reset = 1'b0;
        #1;
        check_val("mid_rst_busy",   64'(busy),     64'd0);
        check_val("mid_rst_done",   64'(done),     64'd0);
        check_val("mid_rst_counts", counts,        64'd0);
        check_val("mid_rst_sat",    64'(sat),      64'd0);
        check_val("mid_rst_resp",   64'(resp),     64'd0);
        check_val("mid_rst_cnt_s",  64'(counts_s), 64'd0);
        check_val("mid_rst_sat_s",  64'(sat_s),    64'd0);
        step();
        Reset = 1'b1;
        det0.delete();
        det1.delete();
        repeat (5) step();
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_done", 64'(done), 64'd0);
        set_waves(4, 6, 1'b1, 1'b1);
        repeat (5) step();
        run_measure(120, 1'b0);

        // Randomised runs.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 2; i++) begin
                per[i] = int'($urandom_range(2, 12));
                ph[i]  = int'($urandom_range(0, 11));
                en[i]  = ($urandom_range(0, 9) != 0);
            end
            repeat ($urandom_range(0, 15)) step();
            run_measure(int'($urandom_range(0, 400)), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
